// File: rtl/pulse_period_meter.sv
// Measures high time, low time and period of an asynchronous square wave in clk cycles,
// delivering each measurement over valid/ready and flagging stuck inputs and dropped results.
module pulse_period_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             sig_in,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] high_len,
   output logic [CNT_W-1:0] low_len,
   output logic [CNT_W:0]   period,
   output logic             stuck,
   output logic             stuck_level,
   output logic             dropped
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_RISE,
      ST_MEAS_HIGH,
      ST_MEAS_LOW
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_high;
   logic                   r_meas_valid;
   logic [CNT_W-1:0]       r_high_len;
   logic [CNT_W-1:0]       r_low_len;
   logic [CNT_W:0]         r_period;
   logic                   r_stuck;
   logic                   r_stuck_level;
   logic                   r_dropped;

   logic w_s;
   logic w_rise;
   logic w_fall;
   logic w_edge;
   logic w_timeout;
   logic w_issue;
   logic w_load;

   assign w_s       = r_sync[SYNC_STAGES-1];
   assign w_rise    = w_s & ~r_prev;
   assign w_fall    = ~w_s & r_prev;
   assign w_edge    = w_rise | w_fall;
   assign w_timeout = (r_state != ST_IDLE) && !w_edge && (r_cnt == TIMEOUT_C);
   assign w_issue   = enable && (r_state == ST_MEAS_LOW) && w_rise;
   assign w_load    = w_issue && (!r_meas_valid || meas_ready);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_sync  <= '0;
         r_prev  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_prev  <= w_s;
      end
   end

   // NOTE: next state gets a default first so no path through the block infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE:      w_state_nxt = ST_WAIT_RISE;
            ST_WAIT_RISE: if (w_rise) w_state_nxt = ST_MEAS_HIGH;
            ST_MEAS_HIGH: begin
               if (w_fall)         w_state_nxt = ST_MEAS_LOW;
               else if (w_timeout) w_state_nxt = ST_WAIT_RISE;
            end
            ST_MEAS_LOW: begin
               if (w_rise)         w_state_nxt = ST_MEAS_HIGH;
               else if (w_timeout) w_state_nxt = ST_WAIT_RISE;
            end
            default:      w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Run counter saturates at TIMEOUT so a stuck input parks it there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_high <= '0;
      end else begin
         if (!enable || r_state == ST_IDLE) r_cnt <= '0;
         else if (w_edge)                   r_cnt <= CNT_W'(1);
         else if (r_cnt != TIMEOUT_C)       r_cnt <= r_cnt + CNT_W'(1);
         if (enable && r_state == ST_MEAS_HIGH && w_fall) r_high <= r_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stuck       <= 1'b0;
         r_stuck_level <= 1'b0;
         r_dropped     <= 1'b0;
      end else if (!enable) begin
         r_stuck       <= 1'b0;
         r_stuck_level <= 1'b0;
         r_dropped     <= 1'b0;
      end else begin
         if (w_edge) begin
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
         end else if (w_timeout) begin
            r_stuck       <= 1'b1;
            r_stuck_level <= w_s;
         end
         if (w_issue && r_meas_valid && !meas_ready) r_dropped <= 1'b1;
      end
   end

   // Output register keeps its data after acceptance; only valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meas_valid <= 1'b0;
         r_high_len   <= '0;
         r_low_len    <= '0;
         r_period     <= '0;
      end else if (w_load) begin
         r_meas_valid <= 1'b1;
         r_high_len   <= r_high;
         r_low_len    <= r_cnt;
         r_period     <= {1'b0, r_high} + {1'b0, r_cnt};
      end else if (r_meas_valid && meas_ready) begin
         r_meas_valid <= 1'b0;
      end
   end

   assign meas_valid  = r_meas_valid;
   assign high_len    = r_high_len;
   assign low_len     = r_low_len;
   assign period      = r_period;
   assign stuck       = r_stuck;
   assign stuck_level = r_stuck_level;
   assign dropped     = r_dropped;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: waveform tasks push expected (high, low)
// pairs, a monitor pops and compares every accepted measurement.
module tb_pulse_period_meter;

   localparam int CNT_W       = 16;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 50;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic             sig_in;
   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [CNT_W:0]   period;
   logic             stuck;
   logic             stuck_level;
   logic             dropped;

   typedef struct {
      int h;
      int l;
   } meas_t;

   meas_t sb_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   pulse_period_meter #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .sig_in     (sig_in),
      .meas_valid (meas_valid),
      .meas_ready (meas_ready),
      .high_len   (high_len),
      .low_len    (low_len),
      .period     (period),
      .stuck      (stuck),
      .stuck_level(stuck_level),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_meas(input int h, input int l, input int n);
      meas_t m;
      m.h = h;
      m.l = l;
      for (int i = 0; i < n; i++) sb_q.push_back(m);
   endtask

   // k periods of h cycles high then l cycles low, starting on a negedge.
   task automatic run_wave(input int h, input int l, input int k);
      for (int i = 0; i < k; i++) begin
         sig_in = 1'b1;
         repeat (h) @(negedge clk);
         sig_in = 1'b0;
         repeat (l) @(negedge clk);
      end
   endtask

   task automatic wait_drain(input int budget);
      int c;
      c = 0;
      while (sb_q.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("drain", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic restart();
      enable     = 1'b0;
      meas_ready = 1'b1;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
   endtask

   // Accept happens on the next posedge whenever valid and ready are both high here.
   always @(negedge clk) begin : monitor
      meas_t e;
      #1;
      if (rst_n && meas_valid && meas_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_meas", 64'(meas_valid), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("high_len", 64'(high_len), 64'(e.h));
            check("low_len",  64'(low_len),  64'(e.l));
            check("period",   64'(period),   64'(e.h + e.l));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      sig_in     = 1'b0;
      meas_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid",    64'(meas_valid), 64'd0);
      check("rst_high_len", 64'(high_len),   64'd0);
      check("rst_low_len",  64'(low_len),    64'd0);
      check("rst_period",   64'(period),     64'd0);
      check("rst_stuck",    64'(stuck),      64'd0);
      check("rst_dropped",  64'(dropped),    64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 10/10 with the consumer always ready
      restart();
      expect_meas(10, 10, 5);
      run_wave(10, 10, 6);
      check("t1_stuck",   64'(stuck),   64'd0);
      check("t1_dropped", 64'(dropped), 64'd0);
      wait_drain(20);

      // minimum pulses
      restart();
      expect_meas(1, 1, 7);
      run_wave(1, 1, 8);
      wait_drain(20);

      // backpressure: 50-cycle stall, first result held, later ones dropped
      restart();
      meas_ready = 1'b0;
      run_wave(3, 7, 2);
      check("bp_valid_a",  64'(meas_valid), 64'd1);
      check("bp_high_a",   64'(high_len),   64'd3);
      check("bp_low_a",    64'(low_len),    64'd7);
      check("bp_period_a", 64'(period),     64'd10);
      run_wave(3, 7, 3);
      check("bp_valid_b",  64'(meas_valid), 64'd1);
      check("bp_high_b",   64'(high_len),   64'd3);
      check("bp_low_b",    64'(low_len),    64'd7);
      check("bp_period_b", 64'(period),     64'd10);
      check("bp_dropped",  64'(dropped),    64'd1);
      meas_ready = 1'b1;
      expect_meas(3, 7, 4);
      run_wave(3, 7, 3);
      wait_drain(20);
      check("bp_dropped_sticky", 64'(dropped), 64'd1);
      restart();
      check("bp_dropped_clear", 64'(dropped), 64'd0);

      // stuck high, then recovery on a 5/5 wave
      repeat (2) @(negedge clk);
      sig_in = 1'b1;
      repeat (40) @(negedge clk);
      check("to_not_yet", 64'(stuck), 64'd0);
      repeat (15) @(negedge clk);
      check("to_stuck",       64'(stuck),       64'd1);
      check("to_stuck_level", 64'(stuck_level), 64'd1);
      check("to_no_valid",    64'(meas_valid),  64'd0);
      sig_in = 1'b0;
      repeat (4) @(negedge clk);
      check("to_clear", 64'(stuck), 64'd0);
      @(negedge clk);
      expect_meas(5, 5, 2);
      run_wave(5, 5, 3);
      wait_drain(30);

      // enable dropped in MEAS_LOW with one result pending
      restart();
      meas_ready = 1'b0;
      run_wave(4, 6, 2);
      enable = 1'b0;
      run_wave(4, 6, 3);
      check("dis_valid",   64'(meas_valid), 64'd1);
      check("dis_high",    64'(high_len),   64'd4);
      check("dis_low",     64'(low_len),    64'd6);
      check("dis_dropped", 64'(dropped),    64'd0);
      expect_meas(4, 6, 1);
      meas_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("dis_valid_cleared", 64'(meas_valid), 64'd0);
      enable = 1'b1;
      expect_meas(4, 6, 1);
      run_wave(4, 6, 2);
      wait_drain(20);

      // asynchronous reset in MEAS_HIGH with a pending result
      restart();
      meas_ready = 1'b0;
      run_wave(4, 6, 2);
      sig_in = 1'b1;
      repeat (4) @(negedge clk);
      check("ar_pre_valid", 64'(meas_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid",   64'(meas_valid), 64'd0);
      check("ar_high",    64'(high_len),   64'd0);
      check("ar_low",     64'(low_len),    64'd0);
      check("ar_period",  64'(period),     64'd0);
      check("ar_stuck",   64'(stuck),      64'd0);
      check("ar_dropped", 64'(dropped),    64'd0);
      sig_in = 1'b0;
      @(negedge clk);
      rst_n      = 1'b1;
      meas_ready = 1'b1;
      @(negedge clk);
      expect_meas(3, 5, 2);
      run_wave(3, 5, 3);
      wait_drain(20);

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Sits directly downstream of the timer square-wave generator and consumes its output waveform.
- Synchronises the waveform, then measures high time, low time and period in clk cycles.
- Delivers each complete measurement over a valid/ready interface.
- Flags a stuck waveform (no edge within a timeout window) and any measurements dropped under backpressure.

Parameters:
- CNT_W, 16, width of the high/low duration counters.
- SYNC_STAGES, 2, number of input synchroniser flops; minimum 2.
- TIMEOUT, 1000, cycles without an edge before stuck is flagged; legal range 2 to 2^CNT_W-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  measurement enable.
- sig_in  input  1  waveform under measurement; asynchronous to clk.
- meas_valid  output  1  a measurement is held in the output register.
- meas_ready  input  1  consumer accepts the measurement.
- high_len  output  CNT_W  cycles the waveform was high.
- low_len  output  CNT_W  cycles the waveform was low.
- period  output  CNT_W+1  high_len + low_len, computed at full width with no truncation.
- stuck  output  1  no edge seen for TIMEOUT cycles.
- stuck_level  output  1  synchronised level while stuck.
- dropped  output  1  sticky: a measurement was discarded because the output register was full.

Behaviour:
- Reset: all outputs 0, synchroniser and prev flop 0, state IDLE, counters 0.
- Synchroniser: SYNC_STAGES flops clocked by clk; s = last stage. prev = s delayed one cycle.
  - rise = s & ~prev
  - fall = ~s & prev
- Run counter cnt (CNT_W bits):
  - On any edge cycle, loads 1.
  - Otherwise increments by 1.
  - Never exceeds TIMEOUT, because the timeout fires first.
- States:
  - IDLE: cnt=0. enable=1 -> WAIT_RISE.
  - WAIT_RISE: discards partial data. rise -> MEAS_HIGH.
  - MEAS_HIGH: fall -> capture h=cnt, go to MEAS_LOW.
  - MEAS_LOW: rise -> capture l=cnt, issue measurement (h, l), go to MEAS_HIGH.
  - Back-to-back measurements share edges; the closing rise of one measurement is the opening rise of the next.
- Timing from WAIT_RISE: a waveform with N cycles high then M cycles low, as seen at s, yields high_len=N, low_len=M.
- Output register:
  - An issued measurement loads when meas_valid=0, or when meas_valid=1 and meas_ready=1 in the same cycle. It then sets meas_valid=1.
  - If meas_valid=1 and meas_ready=0, the new measurement is discarded and dropped is set to 1.
  - While meas_valid=1 and meas_ready=0, high_len, low_len and period hold stable.
  - meas_valid & meas_ready with no new measurement -> meas_valid=0 next cycle; data outputs keep their last value.
- Latency: meas_valid rises on the clk edge at which the closing rise is registered. That is SYNC_STAGES+1 clk edges after sig_in is first sampled high.
- Timeout:
  - In WAIT_RISE, MEAS_HIGH or MEAS_LOW, if cnt==TIMEOUT on a non-edge cycle, then stuck=1, stuck_level=s, and the state goes to WAIT_RISE.
  - The partial measurement is discarded; cnt holds at TIMEOUT.
  - stuck clears on the next edge of s.
  - A rise while stuck starts MEAS_HIGH normally.
- enable=0, from any state:
  - Next state is IDLE; cnt=0, stuck=0, stuck_level=0, dropped=0.
  - A pending meas_valid and its data are retained until accepted.
  - Re-enabling enters WAIT_RISE, so a full rise-fall-rise is needed before the next measurement.
- Edge while enable=0: ignored. prev still tracks s, so no false edge occurs on re-enable.
- Reset asserted mid-operation: immediate return to reset values; any in-flight or pending measurement is lost.

Test Plan:
- Timer defaults, 10 high / 10 low, meas_ready=1, enable=1 -> after the first rise-fall-rise: meas_valid one cycle every 20 cycles, high_len=10, low_len=10, period=20; stuck=0, dropped=0.
- 3 high / 7 low, meas_ready=0 for 50 cycles, then 1 -> first measurement (3, 7, 10) held stable throughout the stall; dropped=1 after the second issue; after the ready cycle the next loaded measurement is (3, 7, 10).
- Minimum pulses, 1 high / 1 low -> high_len=1, low_len=1, period=2, valid every 2 cycles.
- TIMEOUT=50: sig_in rises then stays high -> stuck=1 and stuck_level=1 exactly 50 cycles after the rise is seen at s, with no meas_valid.
  - sig_in then toggles 5/5 -> stuck clears on the fall; the first measurement is only (5, 5, 10) after a full rise-fall-rise.
- enable dropped mid MEAS_LOW with one measurement pending -> the pending measurement remains valid until accepted and no new measurement is issued; after re-enable the first measurement follows a complete rise-fall-rise.
- rst_n pulsed low mid MEAS_HIGH with meas_valid=1 -> all outputs 0 immediately (asynchronously); after release, normal measurements resume from WAIT_RISE.
